// File: rtl/pcileech_pkg.sv
// Shared constants, types and header helpers for the FT601 receive path.
package pcileech_pkg;

  typedef enum logic [1:0] {
    RX_TYPE_TLP = 2'd0,
    RX_TYPE_CFG = 2'd1,
    RX_TYPE_CMD = 2'd2
  } rx_type_t;

  typedef enum logic {
    PH_PAYLOAD = 1'b0,
    PH_HEADER  = 1'b1
  } rx_phase_t;

  localparam logic [31:0] RX_MAGIC  = 32'h6666_5555;
  localparam logic [7:0]  RX_MARKER = 8'h77;

  localparam int HDR_MARK_HI = 31;
  localparam int HDR_MARK_LO = 24;
  localparam int HDR_TYPE_HI = 17;
  localparam int HDR_TYPE_LO = 16;

  function automatic logic hdr_ok(
    input logic [31:0] h,
    input logic [7:0]  marker
  );
    return (h[HDR_MARK_HI:HDR_MARK_LO] == marker) &&
           (h[HDR_TYPE_HI:HDR_TYPE_LO] != 2'd3);
  endfunction

  function automatic logic [1:0] hdr_type(input logic [31:0] h);
    return h[HDR_TYPE_HI:HDR_TYPE_LO];
  endfunction

endpackage

// File: rtl/pcileech_fifo_sync_fwft.sv
// First-word-fall-through synchronous FIFO on distributed RAM.
// Push while full only succeeds when a pop frees the slot in the same cycle.
module pcileech_fifo_sync_fwft #(
  parameter int WIDTH      = 66,
  parameter int DEPTH_LOG2 = 5,
  parameter int AF_MARGIN  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             full,
  output logic             almost_full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT =
    (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_CNT =
    (DEPTH_LOG2+1)'(DEPTH - AF_MARGIN);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  do_wr;
  logic                  do_rd;

  assign valid   = (count != '0);
  assign full    = (count == FULL_CNT);
  assign do_wr   = wr_en && (!full || rd_en);
  assign do_rd   = rd_en && valid;
  assign rd_data = valid ? mem[rd_ptr] : '0;

  always_comb begin
    count_nxt = count;
    unique case ({do_wr, do_rd})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      almost_full <= (count_nxt >= AF_CNT);
    end
  end

endmodule

// File: rtl/pcileech_ft601_rx_deframer.sv
// FT601 DWORD stream to tagged 64-bit words: filler drop, pairing,
// header check, half-word timeout and status counters.
module pcileech_ft601_rx_deframer
  import pcileech_pkg::*;
#(
  parameter int          PARAM_DEPTH_LOG2 = 5,
  parameter int          PARAM_AF_MARGIN  = 4,
  parameter logic [15:0] PARAM_TIMEOUT    = 16'd1024,
  parameter logic [31:0] PARAM_MAGIC      = RX_MAGIC,
  parameter logic [7:0]  PARAM_MARKER     = RX_MARKER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        almost_full,
  output logic [63:0] dout,
  output logic [1:0]  dout_type,
  output logic        dout_valid,
  input  logic        dout_rd_en,
  output logic        overflow,
  output logic        sync_err,
  output logic [15:0] bad_cnt
);

  rx_phase_t   phase, phase_nxt;
  logic [31:0] payload_q, payload_nxt;
  logic [15:0] idle_q, idle_nxt;
  logic        stg_v, stg_v_nxt;
  logic [65:0] stg_data, stg_nxt;
  logic        reject;
  logic        timeout;
  logic        drop;
  logic        fifo_full;
  logic [65:0] fifo_dout;
  logic [1:0]  inc;
  logic [16:0] bad_sum;

  always_comb begin
    phase_nxt   = phase;
    payload_nxt = payload_q;
    idle_nxt    = idle_q;
    stg_v_nxt   = 1'b0;
    stg_nxt     = stg_data;
    reject      = 1'b0;
    timeout     = 1'b0;
    unique case (phase)
      PH_PAYLOAD: begin
        idle_nxt = '0;
        if (din_valid && din != PARAM_MAGIC) begin
          payload_nxt = din;
          phase_nxt   = PH_HEADER;
        end
      end
      PH_HEADER: begin
        // A header arriving on the timeout cycle still wins.
        if (din_valid) begin
          phase_nxt = PH_PAYLOAD;
          idle_nxt  = '0;
          if (hdr_ok(din, PARAM_MARKER)) begin
            stg_v_nxt = 1'b1;
            stg_nxt   = {hdr_type(din), din, payload_q};
          end else begin
            reject = 1'b1;
          end
        end else if (idle_q == PARAM_TIMEOUT - 16'd1) begin
          timeout   = 1'b1;
          phase_nxt = PH_PAYLOAD;
          idle_nxt  = '0;
        end else begin
          idle_nxt = idle_q + 16'd1;
        end
      end
      default: phase_nxt = PH_PAYLOAD;
    endcase
  end

  assign drop    = stg_v && fifo_full && !dout_rd_en;
  assign inc     = {1'b0, reject | timeout} + {1'b0, drop};
  assign bad_sum = {1'b0, bad_cnt} + {15'd0, inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= PH_PAYLOAD;
      payload_q <= '0;
      idle_q    <= '0;
      stg_v     <= 1'b0;
      stg_data  <= '0;
      overflow  <= 1'b0;
      sync_err  <= 1'b0;
      bad_cnt   <= '0;
    end else begin
      phase     <= phase_nxt;
      payload_q <= payload_nxt;
      idle_q    <= idle_nxt;
      stg_v     <= stg_v_nxt;
      stg_data  <= stg_nxt;
      sync_err  <= timeout;
      if (drop) overflow <= 1'b1;
      bad_cnt   <= bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
    end
  end

  pcileech_fifo_sync_fwft #(
    .WIDTH      (66),
    .DEPTH_LOG2 (PARAM_DEPTH_LOG2),
    .AF_MARGIN  (PARAM_AF_MARGIN)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .wr_data     (stg_data),
    .wr_en       (stg_v),
    .rd_en       (dout_rd_en),
    .rd_data     (fifo_dout),
    .valid       (dout_valid),
    .full        (fifo_full),
    .almost_full (almost_full)
  );

  assign dout      = fifo_dout[63:0];
  assign dout_type = fifo_dout[65:64];

endmodule

// File: tb/tb_pcileech_ft601_rx_deframer.sv
// Directed bench for the FT601 receive deframer.
module tb_pcileech_ft601_rx_deframer;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        din_valid;
  logic        almost_full;
  logic [63:0] dout;
  logic [1:0]  dout_type;
  logic        dout_valid;
  logic        dout_rd_en;
  logic        overflow;
  logic        sync_err;
  logic [15:0] bad_cnt;

  int checks;
  int failures;

  pcileech_ft601_rx_deframer dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .almost_full (almost_full),
    .dout        (dout),
    .dout_type   (dout_type),
    .dout_valid  (dout_valid),
    .dout_rd_en  (dout_rd_en),
    .overflow    (overflow),
    .sync_err    (sync_err),
    .bad_cnt     (bad_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the following negedge.
  task automatic put(input logic [31:0] d);
    din       = d;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop();
    dout_rd_en = 1'b1;
    @(negedge clk);
    dout_rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    din_valid  = 1'b0;
    dout_rd_en = 1'b0;
    din        = '0;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({dout_valid, almost_full, overflow, sync_err} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000",
               {dout_valid, almost_full, overflow, sync_err});
    end
    checks++;
    if ({dout, dout_type, bad_cnt} !== 82'd0) begin
      failures++;
      $display("FAIL reset_data dout=%h type=%0d bad=%0d want 0",
               dout, dout_type, bad_cnt);
    end
  endtask

  task automatic test_basic();
    put(32'h6666_5555);
    put(32'h1111_1111);
    put(32'h7700_0000);
    idle(1);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 64'h7700_0000_1111_1111 ||
        dout_type !== 2'd0) begin
      failures++;
      $display("FAIL basic_word v=%b dout=%h type=%0d want 1 7700000011111111 0",
               dout_valid, dout, dout_type);
    end
    checks++;
    if (bad_cnt !== 16'd0) begin
      failures++;
      $display("FAIL basic_bad got=%0d want=0", bad_cnt);
    end
    pop();
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_pop got=%b want=0", dout_valid);
    end
  endtask

  task automatic test_types();
    put(32'hDEAD_BEEF);
    put(32'h7702_0000);
    idle(1);
    checks++;
    if (dout !== 64'h7702_0000_DEAD_BEEF || dout_type !== 2'd2) begin
      failures++;
      $display("FAIL type_cmd dout=%h type=%0d want 77020000deadbeef 2",
               dout, dout_type);
    end
    pop();
    put(32'h0123_4567);
    put(32'h7703_0000);
    idle(2);
    checks++;
    if (dout_valid !== 1'b0 || bad_cnt !== 16'd1) begin
      failures++;
      $display("FAIL type3_reject v=%b bad=%0d want 0 1",
               dout_valid, bad_cnt);
    end
    put(32'h0123_4567);
    put(32'h5500_0000);
    idle(2);
    checks++;
    if (dout_valid !== 1'b0 || bad_cnt !== 16'd2) begin
      failures++;
      $display("FAIL marker_reject v=%b bad=%0d want 0 2",
               dout_valid, bad_cnt);
    end
  endtask

  task automatic test_realign();
    put(32'h1234_5678);
    put(32'h6666_5555);
    idle(2);
    checks++;
    if (dout_valid !== 1'b0 || bad_cnt !== 16'd3) begin
      failures++;
      $display("FAIL magic_header v=%b bad=%0d want 0 3",
               dout_valid, bad_cnt);
    end
    put(32'hAAAA_AAAA);
    put(32'h7701_0000);
    idle(1);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 64'h7701_0000_AAAA_AAAA ||
        dout_type !== 2'd1) begin
      failures++;
      $display("FAIL realign v=%b dout=%h type=%0d want 1 77010000aaaaaaaa 1",
               dout_valid, dout, dout_type);
    end
    pop();
  endtask

  task automatic test_timeout();
    put(32'h1357_2468);
    idle(1023);
    checks++;
    if (sync_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early got=%b want=0", sync_err);
    end
    idle(1);
    checks++;
    if (sync_err !== 1'b1 || bad_cnt !== 16'd4) begin
      failures++;
      $display("FAIL timeout_pulse err=%b bad=%0d want 1 4",
               sync_err, bad_cnt);
    end
    idle(1);
    checks++;
    if (sync_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_width got=%b want=0", sync_err);
    end
    put(32'h0BAD_F00D);
    put(32'h7700_0000);
    idle(1);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 64'h7700_0000_0BAD_F00D) begin
      failures++;
      $display("FAIL timeout_resync v=%b dout=%h want 1 770000000badf00d",
               dout_valid, dout);
    end
    pop();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      put(32'h1000_0000 + 32'(k - 1));
      put(32'h7700_0000);
      idle(1);
      if (k == 27) begin
        checks++;
        if (almost_full !== 1'b0) begin
          failures++;
          $display("FAIL af_27 got=%b want=0", almost_full);
        end
      end
      if (k == 28) begin
        checks++;
        if (almost_full !== 1'b1) begin
          failures++;
          $display("FAIL af_28 got=%b want=1", almost_full);
        end
      end
    end
    checks++;
    if (overflow !== 1'b0 || bad_cnt !== 16'd0) begin
      failures++;
      $display("FAIL full_no_ovf ovf=%b bad=%0d want 0 0",
               overflow, bad_cnt);
    end
    put(32'h1000_0020);
    put(32'h7700_0000);
    idle(1);
    checks++;
    if (overflow !== 1'b1 || bad_cnt !== 16'd1 ||
        dout !== 64'h7700_0000_1000_0000) begin
      failures++;
      $display("FAIL ovf_drop ovf=%b bad=%0d dout=%h want 1 1 7700000010000000",
               overflow, bad_cnt, dout);
    end
    put(32'h1000_0021);
    put(32'h7700_0000);
    pop();
    checks++;
    if (dout_valid !== 1'b1 || bad_cnt !== 16'd1 ||
        almost_full !== 1'b1 || dout !== 64'h7700_0000_1000_0001) begin
      failures++;
      $display("FAIL push_pop_full v=%b bad=%0d af=%b dout=%h want 1 1 1 7700000010000001",
               dout_valid, bad_cnt, almost_full, dout);
    end
    for (int i = 1; i <= 31; i++) begin
      checks++;
      if (dout_valid !== 1'b1 ||
          dout[31:0] !== 32'h1000_0000 + 32'(i)) begin
        failures++;
        $display("FAIL drain_%0d v=%b pay=%h want 1 %h",
                 i, dout_valid, dout[31:0], 32'h1000_0000 + 32'(i));
      end
      pop();
    end
    checks++;
    if (dout_valid !== 1'b1 || dout[31:0] !== 32'h1000_0021) begin
      failures++;
      $display("FAIL drain_last v=%b pay=%h want 1 10000021",
               dout_valid, dout[31:0]);
    end
    pop();
    checks++;
    if (dout_valid !== 1'b0 || almost_full !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty v=%b af=%b want 0 0",
               dout_valid, almost_full);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      put(32'h3000_0000 + 32'(k));
      put(32'h7701_0000);
    end
    put(32'h3333_3333);
    idle(1);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({dout_valid, almost_full, overflow, sync_err} !== 4'b0 ||
        {dout, dout_type, bad_cnt} !== 82'd0) begin
      failures++;
      $display("FAIL async_reset v=%b dout=%h type=%0d bad=%0d want all 0",
               dout_valid, dout, dout_type, bad_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    put(32'h2222_2222);
    put(32'h7701_0000);
    idle(1);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 64'h7701_0000_2222_2222 ||
        dout_type !== 2'd1 || bad_cnt !== 16'd0) begin
      failures++;
      $display("FAIL post_reset v=%b dout=%h type=%0d bad=%0d want 1 7701000022222222 1 0",
               dout_valid, dout, dout_type, bad_cnt);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    dout_rd_en = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_types();
    test_realign();
    test_timeout();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
